// File: rtl/mipi_splitter.sv
// Splits 16-bit stitched words into lane A (low byte) then lane B (high byte) transfers.
// Optional per-lane parity outputs are enabled by defining MIPI_SPLIT_PARITY_EN.
module mipi_splitter #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      mipi_in,
  input  logic             mipi_in_valid,
  output logic             mipi_in_ready,
  output logic [7:0]       mipi_a,
  output logic             mipi_a_valid,
  input  logic             mipi_a_ready,
  output logic [7:0]       mipi_b,
  output logic             mipi_b_valid,
  input  logic             mipi_b_ready,
  output logic [LVL_W-1:0] fifo_level
`ifdef MIPI_SPLIT_PARITY_EN
  ,
  output logic             mipi_a_par,
  output logic             mipi_b_par
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND_A,
    SEND_B
  } state_t;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] count_reg;
  logic [15:0]      head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full          = (count_reg == LVL_W'(DEPTH));
  assign empty         = (count_reg == '0);
  assign mipi_in_ready = !rst && !full;
  assign push          = mipi_in_valid && mipi_in_ready;
  assign head          = mem[rd_ptr_reg];
  assign fifo_level    = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= mipi_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LVL_W'(1);
        2'b01:   count_reg <= count_reg - LVL_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  state_t     state_reg, state_next;
  logic [7:0] hold_reg, hold_next;
  logic [7:0] a_reg, a_next;
  logic [7:0] b_reg, b_next;
  logic       a_valid_reg, a_valid_next;
  logic       b_valid_reg, b_valid_next;

  // Only the high byte must outlive the pop; the low byte goes straight to lane A.
  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    a_valid_next = a_valid_reg;
    b_valid_next = b_valid_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          hold_next    = head[15:8];
          a_next       = head[7:0];
          a_valid_next = 1'b1;
          state_next   = SEND_A;
        end
      end
      SEND_A: begin
        if (mipi_a_ready) begin
          a_valid_next = 1'b0;
          b_next       = hold_reg;
          b_valid_next = 1'b1;
          state_next   = SEND_B;
        end
      end
      SEND_B: begin
        if (mipi_b_ready) begin
          b_valid_next = 1'b0;
          if (!empty) begin
            pop          = 1'b1;
            hold_next    = head[15:8];
            a_next       = head[7:0];
            a_valid_next = 1'b1;
            state_next   = SEND_A;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      hold_reg    <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      a_valid_reg <= 1'b0;
      b_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      a_valid_reg <= a_valid_next;
      b_valid_reg <= b_valid_next;
    end
  end

  assign mipi_a       = a_reg;
  assign mipi_b       = b_reg;
  assign mipi_a_valid = a_valid_reg;
  assign mipi_b_valid = b_valid_reg;

`ifdef MIPI_SPLIT_PARITY_EN
  logic a_par_reg;
  logic b_par_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_par_reg <= 1'b0;
      b_par_reg <= 1'b0;
    end else begin
      a_par_reg <= ^a_next;
      b_par_reg <= ^b_next;
    end
  end

  assign mipi_a_par = a_par_reg;
  assign mipi_b_par = b_par_reg;
`endif

endmodule
